// File: rtl/mod_counter_updown.sv
// Parametrised modulo-N up/down counter with clear, clamped load, cascade tc and saturating wrap tally.
// Build option: define MOD_COUNTER_SATURATE_EN to make counting stop at the range ends instead of wrapping.
module mod_counter_updown #(
   parameter int WIDTH       = 3,
   parameter int MODULUS     = 7,
   parameter int RESET_VALUE = 0,
   parameter int WRAPS_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   up,
   input  logic                   clr,
   input  logic                   load,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       count,
   output logic                   tc,
   output logic                   wrap,
   output logic [WRAPS_WIDTH-1:0] wraps
);

   localparam logic [WIDTH-1:0]       max_count   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]         modulus_ext = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0]       reset_count = WIDTH'(RESET_VALUE);
   localparam logic [WRAPS_WIDTH-1:0] wraps_max   = '1;

   logic [WIDTH-1:0]       count_reg, count_next;
   logic                   wrap_reg, wrap_next;
   logic [WRAPS_WIDTH-1:0] wraps_reg, wraps_next;
   logic                   boundary;

   // boundary is the end of the range in the current direction
   assign boundary = up ? (count_reg == max_count) : (count_reg == '0);
   assign tc       = en & boundary;

   always_comb begin
      count_next = count_reg;
      wrap_next  = 1'b0;
      wraps_next = wraps_reg;
      if (clr) begin
         count_next = '0;
         wraps_next = '0;
      end else if (load) begin
         // out-of-range load values clamp to the top of the range
         count_next = ({1'b0, din} < modulus_ext) ? din : max_count;
      end else if (en) begin
         if (!boundary) begin
            count_next = up ? count_reg + 1'b1 : count_reg - 1'b1;
         end else begin
`ifdef MOD_COUNTER_SATURATE_EN
            count_next = count_reg;
`else
            count_next = up ? '0 : max_count;
            wrap_next  = 1'b1;
            if (wraps_reg != wraps_max)
               wraps_next = wraps_reg + 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= reset_count;
         wrap_reg  <= 1'b0;
         wraps_reg <= '0;
      end else begin
         count_reg <= count_next;
         wrap_reg  <= wrap_next;
         wraps_reg <= wraps_next;
      end
   end

   assign count = count_reg;
   assign wrap  = wrap_reg;
   assign wraps = wraps_reg;

endmodule
